// File: rtl/route_demux4.sv
// route_demux4: steers one valid/ready producer stream to four consumer channels.
// Each channel owns a small FIFO, so a stalled consumer only blocks words for it.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   in_valid/in_ready   producer handshake; in_sel picks the destination channel
//   in_data             word to route
//   outK_data           head entry of channel K FIFO (K = 0..3)
//   out_valid[K]        channel K FIFO is non-empty
//   out_ready[K]        consumer K takes the head word this cycle
//   occK                current entry count of channel K
module route_demux4 #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNTW  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [1:0]       in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic [WIDTH-1:0] out1_data,
  output logic [WIDTH-1:0] out2_data,
  output logic [WIDTH-1:0] out3_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [CNTW-1:0]  occ0,
  output logic [CNTW-1:0]  occ1,
  output logic [CNTW-1:0]  occ2,
  output logic [CNTW-1:0]  occ3
);

  localparam int unsigned NCH = 4;
  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem    [NCH][DEPTH];
  logic [PW-1:0]    wr_ptr [NCH];
  logic [PW-1:0]    rd_ptr [NCH];
  logic [CNTW-1:0]  count  [NCH];
  logic [NCH-1:0]   push;
  logic [NCH-1:0]   pop;

  // Ready looks only at the selected channel's count, never at out_ready,
  // so there is no combinational path from any consumer back to the producer.
  assign in_ready = (count[in_sel] != CNTW'(DEPTH));

  // Per-channel push/pop strobes.
  always_comb begin
    push = '0;
    pop  = '0;
    for (int k = 0; k < NCH; k++) begin
      push[k] = in_valid && in_ready && (in_sel == 2'(k));
      pop[k]  = out_valid[k] && out_ready[k];
    end
  end

  // FIFO storage, pointers and counts; reset clears storage too so heads read 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        count[k]  <= '0;
        for (int d = 0; d < DEPTH; d++) begin
          mem[k][d] <= '0;
        end
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (push[k]) begin
          mem[k][wr_ptr[k]] <= in_data;
          wr_ptr[k]         <= wr_ptr[k] + PW'(1);
        end
        if (pop[k]) begin
          rd_ptr[k] <= rd_ptr[k] + PW'(1);
        end
        count[k] <= count[k] + CNTW'(push[k]) - CNTW'(pop[k]);
      end
    end
  end

  // Head word and status per channel, all taken straight from registers.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      out_valid[k] = (count[k] != '0);
    end
  end

  assign out0_data = mem[0][rd_ptr[0]];
  assign out1_data = mem[1][rd_ptr[1]];
  assign out2_data = mem[2][rd_ptr[2]];
  assign out3_data = mem[3][rd_ptr[3]];

  assign occ0 = count[0];
  assign occ1 = count[1];
  assign occ2 = count[2];
  assign occ3 = count[3];

endmodule
